// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: opcode encodings and fetch FSM states shared with the control unit
package instr_fetch_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_0 = 3'd0;
  localparam logic [OP_W-1:0] OP_1 = 3'd1;
  localparam logic [OP_W-1:0] OP_2 = 3'd2;
  localparam logic [OP_W-1:0] OP_3 = 3'd3;
  localparam logic [OP_W-1:0] OP_4 = 3'd4;
  localparam logic [OP_W-1:0] OP_5 = 3'd5;
  localparam logic [OP_W-1:0] OP_6 = 3'd6;
  localparam logic [OP_W-1:0] OP_7 = 3'd7;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
endpackage

// File: rtl/instr_fetch_pc_reg.sv
// instr_fetch_pc_reg: program counter with load-over-increment priority and natural wrap
module instr_fetch_pc_reg #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_d, pc_q;
  always_comb pc_d = load ? load_val : inc ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk or negedge clr)
    if (!clr) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one instruction word per en_fetch into the IR and advances the PC.
// Optional WAIT timeout with sticky fetch_err when FETCH_TIMEOUT_EN is defined.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter int OP_W = instr_fetch_pkg::OP_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en_fetch,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [OP_W-1:0]    op,
  output logic [ADDR_W-1:0]  operand,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_err
);
  state_e state_d, state_q;
  logic mem_req_d, mem_req_q, instr_valid_d, instr_valid_q, squash_d, squash_q, pc_inc;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic unused_ir;
`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic err_d, err_q, tmo;
  assign tmo = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
`endif
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d = ir_q;
    squash_d = squash_q;
    instr_valid_d = 1'b0;
    pc_inc = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    err_d = err_q;
    cnt_d = (state_q == WAIT && !mem_rvalid) ? cnt_q + 1'b1 : '0;
`endif
    if (state_q == IDLE) begin
      if (en_fetch) begin
        state_d = WAIT;
        mem_req_d = 1'b1;
        mem_addr_d = pc;
      end
    end else if (mem_rvalid) begin
      state_d = IDLE;
      mem_req_d = 1'b0;
      squash_d = 1'b0;
      // a jump in the completing cycle squashes this word too
      if (!(squash_q || jump)) begin
        ir_d = mem_rdata;
        instr_valid_d = 1'b1;
        pc_inc = 1'b1;
      end
    end else begin
      squash_d = squash_q | jump;
`ifdef FETCH_TIMEOUT_EN
      if (tmo) begin
        state_d = IDLE;
        mem_req_d = 1'b0;
        squash_d = 1'b0;
        err_d = 1'b1;
        cnt_d = '0;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
      ir_q <= '0;
      instr_valid_q <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q <= ir_d;
      instr_valid_q <= instr_valid_d;
      squash_q <= squash_d;
    end
`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif
  instr_fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk(clk),
    .clr(clr),
    .load(jump),
    .load_val(jump_addr),
    .inc(pc_inc),
    .pc(pc)
  );
  assign unused_ir = ^ir_q[INSTR_W-OP_W-1:ADDR_W];
  assign mem_req = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign op = ir_q[INSTR_W-1 -: OP_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign instr_valid = instr_valid_q;
  assign busy = state_q == WAIT;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus reset, timeout and macro-off sequences
module tb_instr_fetch;
  logic clk = 1'b0, clr = 1'b0, en_fetch = 1'b0, jump = 1'b0, mem_rvalid = 1'b0;
  logic [7:0] jump_addr = '0, mem_addr, operand, pc;
  logic [15:0] mem_rdata = '0;
  logic mem_req, instr_valid, busy, fetch_err;
  logic [2:0] op;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .clr(clr), .en_fetch(en_fetch), .jump(jump), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .op(op), .operand(operand), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic en, j;
    logic [7:0] ja;
    logic rv;
    logic [15:0] rd;
    logic req;
    logic [7:0] addr;
    logic [2:0] op;
    logic [7:0] opnd;
    logic iv;
    logic [7:0] pc;
    logic busy;
  } vec_t;

  function automatic vec_t mk(logic en, logic j, logic [7:0] ja, logic rv, logic [15:0] rd,
                              logic req, logic [7:0] addr, logic [2:0] o, logic [7:0] opnd,
                              logic iv, logic [7:0] p, logic b);
    vec_t v;
    v.en = en; v.j = j; v.ja = ja; v.rv = rv; v.rd = rd;
    v.req = req; v.addr = addr; v.op = o; v.opnd = opnd; v.iv = iv; v.pc = p; v.busy = b;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en_fetch = 1'b0; jump = 1'b0; jump_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  vec_t v[20];
  int hi;

  initial begin
    // after each edge: req addr op opnd iv pc busy
    v[0]  = mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 3'd0, 8'h00, 0, 8'h00, 1);
    v[1]  = mk(0, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 3'd0, 8'h00, 0, 8'h00, 1);
    v[2]  = mk(0, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 3'd0, 8'h00, 0, 8'h00, 1);
    v[3]  = mk(0, 0, 8'h00, 1, 16'h2A05, 0, 8'h00, 3'd1, 8'h05, 1, 8'h01, 0);
    v[4]  = mk(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 3'd1, 8'h05, 0, 8'h01, 0);
    v[5]  = mk(0, 0, 8'h00, 1, 16'hFFFF, 0, 8'h00, 3'd1, 8'h05, 0, 8'h01, 0);
    v[6]  = mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h01, 3'd1, 8'h05, 0, 8'h01, 1);
    v[7]  = mk(0, 1, 8'h40, 0, 16'h0000, 1, 8'h01, 3'd1, 8'h05, 0, 8'h40, 1);
    v[8]  = mk(0, 0, 8'h00, 1, 16'h1234, 0, 8'h01, 3'd1, 8'h05, 0, 8'h40, 0);
    v[9]  = mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h40, 3'd1, 8'h05, 0, 8'h40, 1);
    v[10] = mk(0, 0, 8'h00, 1, 16'hE0AB, 0, 8'h40, 3'd7, 8'hAB, 1, 8'h41, 0);
    v[11] = mk(0, 1, 8'hFF, 0, 16'h0000, 0, 8'h40, 3'd7, 8'hAB, 0, 8'hFF, 0);
    v[12] = mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'hFF, 3'd7, 8'hAB, 0, 8'hFF, 1);
    v[13] = mk(0, 0, 8'h00, 1, 16'h4C11, 0, 8'hFF, 3'd2, 8'h11, 1, 8'h00, 0);
    v[14] = mk(1, 1, 8'h80, 0, 16'h0000, 1, 8'h00, 3'd2, 8'h11, 0, 8'h80, 1);
    v[15] = mk(0, 0, 8'h00, 1, 16'h6033, 0, 8'h00, 3'd3, 8'h33, 1, 8'h81, 0);
    v[16] = mk(1, 0, 8'h00, 1, 16'hAAAA, 1, 8'h81, 3'd3, 8'h33, 0, 8'h81, 1);
    v[17] = mk(1, 0, 8'h00, 1, 16'h8177, 0, 8'h81, 3'd4, 8'h77, 1, 8'h82, 0);
    v[18] = mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h82, 3'd4, 8'h77, 0, 8'h82, 1);
    v[19] = mk(0, 1, 8'h10, 1, 16'hA0C3, 0, 8'h82, 3'd4, 8'h77, 0, 8'h10, 0);

    #1;
    chk("reset_state", {mem_req, mem_addr, op, operand, instr_valid, pc, busy, fetch_err},
        {1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    do_reset();

    for (int i = 0; i < 20; i++) begin
      en_fetch = v[i].en; jump = v[i].j; jump_addr = v[i].ja;
      mem_rvalid = v[i].rv; mem_rdata = v[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {mem_req, mem_addr, op, operand, instr_valid, pc, busy},
          {v[i].req, v[i].addr, v[i].op, v[i].opnd, v[i].iv, v[i].pc, v[i].busy});
      @(negedge clk);
    end
    idle_inputs();

    // async reset in the middle of a fetch, then a late rvalid must be ignored
    @(negedge clk);
    en_fetch = 1'b1;
    @(negedge clk);
    en_fetch = 1'b0;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("async_reset", {mem_req, pc, op, instr_valid, operand},
        {1'b0, 8'h00, 3'd0, 1'b0, 8'h00});
    @(negedge clk);
    clr = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("late_rvalid_ignored", {op, operand, instr_valid, pc, busy},
        {3'd0, 8'h00, 1'b0, 8'h00, 1'b0});
    idle_inputs();

    // fetch with no response: timeout when enabled, otherwise wait indefinitely
    do_reset();
    en_fetch = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_fetch = 1'b0;
    hi = 0;
    while (mem_req && hi < 100) begin
      hi++;
      @(negedge clk);
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_req_cycles", hi, 16);
    chk("timeout_err", {31'd0, fetch_err}, 32'd1);
    repeat (3) @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 16'hE0FF;
    @(posedge clk);
    #1;
    chk("timeout_sticky", {fetch_err, busy, instr_valid, op, pc},
        {1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
    mem_rvalid = 1'b0;
    do_reset();
    #1;
    chk("err_cleared", {31'd0, fetch_err}, 32'd0);
`else
    chk("no_timeout_req", {31'd0, mem_req}, 32'd1);
    chk("no_timeout_cycles", hi, 100);
    chk("no_err", {fetch_err, busy, pc}, {1'b0, 1'b1, 8'h00});
    mem_rvalid = 1'b1; mem_rdata = 16'h2A05;
    @(posedge clk);
    #1;
    chk("late_complete", {mem_req, op, operand, instr_valid, pc},
        {1'b0, 3'd1, 8'h05, 1'b1, 8'h01});
    mem_rvalid = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
